// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_pkg
//   Constants and types that the VGA raster timing generator and its per-axis
//   timer share.
//   - COUNT_W          : width of the column/row counters and of the phase
//                        down-counters
//   - MAX_TOTAL        : largest total (active + porches + sync) on one axis
//   - DEF_*            : 800x600@72Hz timing (1040 x 666 total)
//   - phase_e          : phase of one axis, ACTIVE -> FP -> SYNC -> BP
//   - next_phase()     : successor of a phase in that cycle
// ---------------------------------------------------------------------------
package vga_timing_gen_pkg;

    localparam int COUNT_W   = 12;
    localparam int MAX_TOTAL = 4096;

    // 800x600@72Hz
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 56;
    localparam int DEF_H_SYNC   = 120;
    localparam int DEF_H_BP     = 64;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 37;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 23;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            PH_ACTIVE: n = PH_FP;
            PH_FP:     n = PH_SYNC;
            PH_SYNC:   n = PH_BP;
            default:   n = PH_ACTIVE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// ---------------------------------------------------------------------------
// vga_axis_timer
//   Timing for one raster axis (horizontal or vertical). A phase FSM cycles
//   ACTIVE -> FP -> SYNC -> BP -> ACTIVE; each phase is timed by a
//   down-counter loaded with the phase length minus 1. The timer also keeps
//   the absolute position on the axis, 0 .. TOTAL-1.
//
//   Ports
//     i_Clk     in   1        clock, rising edge
//     i_Reset   in   1        synchronous active-high reset -> ACTIVE, pos 0
//     i_Step    in   1        advance one position on this edge
//     o_Phase   out  2        current phase (phase_e encoding)
//     o_Count   out  COUNT_W  current position on the axis
//     o_Wrap    out  1        current position is the last one of BP; the
//                             next step returns the axis to position 0
// ---------------------------------------------------------------------------
module vga_axis_timer
    import vga_timing_gen_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Step,
    output logic [1:0]         o_Phase,
    output logic [COUNT_W-1:0] o_Count,
    output logic               o_Wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    generate
        if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_width
            $error("vga_axis_timer: every phase width must be at least 1");
        end
        if (TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_axis_timer: axis total exceeds 4096");
        end
    endgenerate

    phase_e             phase;
    phase_e             phase_nxt;
    logic [COUNT_W-1:0] down;
    logic [COUNT_W-1:0] down_nxt;
    logic [COUNT_W-1:0] pos;
    logic [COUNT_W-1:0] pos_nxt;

    function automatic logic [COUNT_W-1:0] phase_len_m1(input phase_e p);
        logic [COUNT_W-1:0] len;
        case (p)
            PH_ACTIVE: len = COUNT_W'(ACTIVE - 1);
            PH_FP:     len = COUNT_W'(FP - 1);
            PH_SYNC:   len = COUNT_W'(SYNC - 1);
            default:   len = COUNT_W'(BP - 1);
        endcase
        return len;
    endfunction

    // State register
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            phase <= PH_ACTIVE;
            down  <= COUNT_W'(ACTIVE - 1);
            pos   <= '0;
        end else if (i_Step) begin
            phase <= phase_nxt;
            down  <= down_nxt;
            pos   <= pos_nxt;
        end
    end

    // Next state: a phase ends when its down-counter reaches zero; the
    // position returns to zero after the last BP position.
    always_comb begin
        phase_nxt = phase;
        down_nxt  = down - 1'b1;
        pos_nxt   = pos + 1'b1;
        if (down == '0) begin
            phase_nxt = next_phase(phase);
            down_nxt  = phase_len_m1(next_phase(phase));
        end
        if (o_Wrap) begin
            pos_nxt = '0;
        end
    end

    // Outputs
    always_comb begin
        o_Phase = phase;
        o_Count = pos;
        o_Wrap  = (phase == PH_BP) && (down == '0);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Free-running VGA raster timing source. Two vga_axis_timer instances
//   track the horizontal and vertical position; the vertical axis steps once
//   per line, on the enabled clock where the horizontal axis wraps. The
//   decode of the current position is registered, so every output is aligned
//   and shows pixel k after the (k+1)-th enabled edge since reset.
//
//   Ports
//     i_Clk          in   1   clock, rising edge
//     i_Reset        in   1   synchronous active-high reset, overrides i_Pix_En
//     i_Pix_En       in   1   pixel enable (tie high when i_Clk is pixel clock)
//     o_HSync        out  1   horizontal sync, asserted level H_POL
//     o_VSync        out  1   vertical sync, asserted level V_POL
//     o_Active       out  1   pixel lies in the visible area
//     o_Line_Start   out  1   single-clock strobe on column 0
//     o_Frame_Start  out  1   single-clock strobe on column 0, row 0
//     o_Col_Count    out  12  column of the pixel shown
//     o_Row_Count    out  12  row of the pixel shown
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Pix_En,
    output logic        o_HSync,
    output logic        o_VSync,
    output logic        o_Active,
    output logic        o_Line_Start,
    output logic        o_Frame_Start,
    output logic [11:0] o_Col_Count,
    output logic [11:0] o_Row_Count
);

    logic [1:0]         h_phase;
    logic [1:0]         v_phase;
    logic [COUNT_W-1:0] h_count;
    logic [COUNT_W-1:0] v_count;
    logic               h_wrap;
    logic               v_wrap;
    logic               v_step;
    logic               at_origin;

    logic               active_p0;
    logic               hsync_p0;
    logic               vsync_p0;
    logic               line_start_p0;
    logic               frame_start_p0;

    logic               active_p1;
    logic               hsync_p1;
    logic               vsync_p1;
    logic               line_start_p1;
    logic               frame_start_p1;
    logic [COUNT_W-1:0] col_p1;
    logic [COUNT_W-1:0] row_p1;

    assign v_step = i_Pix_En & h_wrap;

    vga_axis_timer #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_timer (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Step  (i_Pix_En),
        .o_Phase (h_phase),
        .o_Count (h_count),
        .o_Wrap  (h_wrap)
    );

    vga_axis_timer #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_timer (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Step  (v_step),
        .o_Phase (v_phase),
        .o_Count (v_count),
        .o_Wrap  (v_wrap)
    );

    // Flags that the position is (0,0). It is set by reset and by the step
    // that wraps both axes at once, which avoids a compare on both counters.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            at_origin <= 1'b1;
        end else if (i_Pix_En) begin
            at_origin <= h_wrap & v_wrap;
        end
    end

    // ---- p0: decode of the current position ----
    always_comb begin
        active_p0      = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
        hsync_p0       = (h_phase == PH_SYNC) ? H_POL : ~H_POL;
        vsync_p0       = (v_phase == PH_SYNC) ? V_POL : ~V_POL;
        line_start_p0  = (h_count == '0);
        frame_start_p0 = at_origin;
    end

    // ---- p1: registered outputs ----
    // With the enable low everything holds except the strobes, which clear
    // so that each strobe lasts exactly one i_Clk.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            active_p1      <= 1'b0;
            hsync_p1       <= ~H_POL;
            vsync_p1       <= ~V_POL;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
            col_p1         <= '0;
            row_p1         <= '0;
        end else if (i_Pix_En) begin
            active_p1      <= active_p0;
            hsync_p1       <= hsync_p0;
            vsync_p1       <= vsync_p0;
            line_start_p1  <= line_start_p0;
            frame_start_p1 <= frame_start_p0;
            col_p1         <= h_count;
            row_p1         <= v_count;
        end else begin
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
        end
    end

    assign o_Active      = active_p1;
    assign o_HSync       = hsync_p1;
    assign o_VSync       = vsync_p1;
    assign o_Line_Start  = line_start_p1;
    assign o_Frame_Start = frame_start_p1;
    assign o_Col_Count   = col_p1;
    assign o_Row_Count   = row_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    typedef struct packed {
        logic [11:0] col;
        logic [11:0] row;
        logic        act;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        bit   rst;
        bit   en;
        obs_t exp;
    } vec_t;

    logic clk;
    logic rst_d, en_d, rst_s, en_s;

    logic        hs_d, vs_d, act_d, ls_d, fs_d;
    logic [11:0] col_d, row_d;
    logic        hs_s, vs_s, act_s, ls_s, fs_s;
    logic [11:0] col_s, row_s;

    obs_t obs_d, obs_s;
    obs_t mdl_d, mdl_s;
    cfg_t cfg_d, cfg_s;
    int   n_d, n_s;

    int tests;
    int fails;

    vga_timing_gen dut_d (
        .i_Clk         (clk),
        .i_Reset       (rst_d),
        .i_Pix_En      (en_d),
        .o_HSync       (hs_d),
        .o_VSync       (vs_d),
        .o_Active      (act_d),
        .o_Line_Start  (ls_d),
        .o_Frame_Start (fs_d),
        .o_Col_Count   (col_d),
        .o_Row_Count   (row_d)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .H_POL    (1'b0), .V_POL (1'b0)
    ) dut_s (
        .i_Clk         (clk),
        .i_Reset       (rst_s),
        .i_Pix_En      (en_s),
        .o_HSync       (hs_s),
        .o_VSync       (vs_s),
        .o_Active      (act_s),
        .o_Line_Start  (ls_s),
        .o_Frame_Start (fs_s),
        .o_Col_Count   (col_s),
        .o_Row_Count   (row_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb obs_d = {col_d, row_d, act_d, hs_d, vs_d, ls_d, fs_d};
    always_comb obs_s = {col_s, row_s, act_s, hs_s, vs_s, ls_s, fs_s};

    // ---------------- reference model ----------------
    function automatic obs_t reset_obs(input cfg_t c);
        obs_t o;
        o     = '0;
        o.hs  = ~c.hp;
        o.vs  = ~c.vp;
        return o;
    endfunction

    // Outputs for the n-th pixel of the raster since reset.
    function automatic obs_t pixel_obs(input cfg_t c, input int n);
        obs_t o;
        int ht, vt, col, row, hs0, vs0;
        ht    = c.ha + c.hf + c.hs + c.hb;
        vt    = c.va + c.vf + c.vs + c.vb;
        col   = n % ht;
        row   = (n / ht) % vt;
        hs0   = c.ha + c.hf;
        vs0   = c.va + c.vf;
        o.col = 12'(col);
        o.row = 12'(row);
        o.act = (col < c.ha) && (row < c.va);
        o.hs  = (col >= hs0 && col < hs0 + c.hs) ? c.hp : ~c.hp;
        o.vs  = (row >= vs0 && row < vs0 + c.vs) ? c.vp : ~c.vp;
        o.ls  = (col == 0);
        o.fs  = (col == 0) && (row == 0);
        return o;
    endfunction

    task automatic model_edge(input cfg_t c, inout int n, inout obs_t m,
                              input bit r, input bit e);
        if (r) begin
            n = 0;
            m = reset_obs(c);
        end else if (e) begin
            m = pixel_obs(c, n);
            n = n + 1;
        end else begin
            m.ls = 1'b0;
            m.fs = 1'b0;
        end
    endtask

    function automatic string fmt(input obs_t o);
        return $sformatf("col=%0d row=%0d act=%b hs=%b vs=%b ls=%b fs=%b",
                         o.col, o.row, o.act, o.hs, o.vs, o.ls, o.fs);
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(want));
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // One clock for both instances; each is compared with its model.
    task automatic step(input bit rd, input bit ed, input bit rs, input bit es);
        rst_d = rd; en_d = ed; rst_s = rs; en_s = es;
        @(posedge clk);
        model_edge(cfg_d, n_d, mdl_d, rd, ed);
        model_edge(cfg_s, n_s, mdl_s, rs, es);
        @(negedge clk);
        check_obs("model_800x600", obs_d, mdl_d);
        check_obs("model_small", obs_s, mdl_s);
    endtask

    task automatic step_d(input bit r, input bit e);
        step(r, e, 1'b0, 1'b0);
    endtask

    task automatic step_s(input bit r, input bit e);
        step(1'b0, 1'b0, r, e);
    endtask

    function automatic vec_t mk(input bit r, input bit e, input int c, input int rw,
                                input bit a, input bit h, input bit v,
                                input bit l, input bit f);
        vec_t t;
        t.rst     = r;
        t.en      = e;
        t.exp.col = 12'(c);
        t.exp.row = 12'(rw);
        t.exp.act = a;
        t.exp.hs  = h;
        t.exp.vs  = v;
        t.exp.ls  = l;
        t.exp.fs  = f;
        return t;
    endfunction

    vec_t tbl [13];
    int   guard;
    int   hs_cnt, hs_min, hs_max, act_cnt, vs_cnt, vs_min, vs_max;
    int   saved_row;
    int   ls_q [$];

    initial begin
        tests = 0;
        fails = 0;
        rst_d = 1'b1; en_d = 1'b0; rst_s = 1'b1; en_s = 1'b0;
        n_d = 0; n_s = 0;
        cfg_d = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};
        cfg_s = '{8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0};
        mdl_d = reset_obs(cfg_d);
        mdl_s = reset_obs(cfg_s);

        // Reset, first pixels, enable hold, reset overriding enable.
        //           rst en col row act hs vs ls fs
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 1, 0, 0, 1, 1);
        tbl[6]  = mk(0, 1, 1, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 2, 0, 1, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 1, 0, 0, 1, 1);
        tbl[12] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].en, 1'b1, 1'b0);
            check_obs($sformatf("table[%0d]", i), obs_d, tbl[i].exp);
        end

        // Two full lines: HSync, Active and Line_Start over row 1.
        hs_cnt = 0; hs_min = 4096; hs_max = -1; act_cnt = 0;
        for (int i = 0; i < 2080; i++) begin
            step_d(1'b0, 1'b1);
            if (row_d == 12'd1) begin
                if (hs_d) begin
                    hs_cnt++;
                    if (int'(col_d) < hs_min) hs_min = int'(col_d);
                    if (int'(col_d) > hs_max) hs_max = int'(col_d);
                end
                if (act_d) act_cnt++;
            end
            if (ls_d) ls_q.push_back(i);
        end
        check_int("hsync_width", hs_cnt, 120);
        check_int("hsync_first_col", hs_min, 856);
        check_int("hsync_last_col", hs_max, 975);
        check_int("active_cols", act_cnt, 800);
        check_int("line_start_count", ls_q.size(), 2);
        if (ls_q.size() >= 2) check_int("line_start_period", ls_q[1] - ls_q[0], 1040);

        // Enable 1,0,0,1 around column 1039.
        guard = 0;
        while (col_d != 12'd1039 && guard < 1200) begin
            step_d(1'b0, 1'b1);
            guard++;
        end
        check_int("reach_col_1039", int'(col_d), 1039);
        saved_row = int'(row_d);
        step_d(1'b0, 1'b0);
        check_int("hold1_col", int'(col_d), 1039);
        check_int("hold1_row", int'(row_d), saved_row);
        step_d(1'b0, 1'b0);
        check_int("hold2_col", int'(col_d), 1039);
        step_d(1'b0, 1'b1);
        check_int("wrap_col", int'(col_d), 0);
        check_int("wrap_row", int'(row_d), saved_row + 1);
        check_int("wrap_line_start", int'(ls_d), 1);
        step_d(1'b0, 1'b0);
        check_int("line_start_single", int'(ls_d), 0);
        check_int("hold3_row", int'(row_d), saved_row + 1);

        // Reset pulse mid-line at column 500.
        guard = 0;
        while (col_d != 12'd500 && guard < 1200) begin
            step_d(1'b0, 1'b1);
            guard++;
        end
        check_int("reach_col_500", int'(col_d), 500);
        step_d(1'b1, 1'b0);
        check_obs("mid_reset", obs_d, mk(0, 0, 0, 0, 0, 0, 0, 0, 0).exp);
        step_d(1'b0, 1'b1);
        check_obs("after_reset", obs_d, mk(0, 0, 0, 0, 1, 0, 0, 1, 1).exp);

        // Random enable and rare reset, default timing.
        for (int i = 0; i < 15000; i++) begin
            step_d($urandom_range(0, 2999) == 0, $urandom_range(0, 3) != 0);
        end

        // Small timing, negative polarities: one whole frame and its wrap.
        step_s(1'b1, 1'b0);
        hs_cnt = 0; hs_min = 4096; hs_max = -1;
        vs_cnt = 0; vs_min = 4096; vs_max = -1;
        for (int i = 0; i < 112; i++) begin
            step_s(1'b0, 1'b1);
            if (!hs_s) begin
                hs_cnt++;
                if (int'(col_s) < hs_min) hs_min = int'(col_s);
                if (int'(col_s) > hs_max) hs_max = int'(col_s);
            end
            if (!vs_s) begin
                vs_cnt++;
                if (int'(row_s) < vs_min) vs_min = int'(row_s);
                if (int'(row_s) > vs_max) vs_max = int'(row_s);
            end
        end
        check_int("small_hsync_cycles", hs_cnt, 24);
        check_int("small_hsync_first", hs_min, 10);
        check_int("small_hsync_last", hs_max, 12);
        check_int("small_vsync_cycles", vs_cnt, 28);
        check_int("small_vsync_first", vs_min, 5);
        check_int("small_vsync_last", vs_max, 6);
        check_int("small_last_col", int'(col_s), 13);
        check_int("small_last_row", int'(row_s), 7);
        step_s(1'b0, 1'b1);
        check_obs("small_frame_wrap", obs_s, mk(0, 0, 0, 0, 1, 1, 1, 1, 1).exp);

        // Random enable and rare reset, small timing.
        for (int i = 0; i < 20000; i++) begin
            step_s($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
